// File: rtl/rs_age_ordered.sv
// Age-ordered reservation station: buffers dispatched ops until both
// operands arrive over the CDBs, then issues the oldest ready op to the ALU.
//
// Ports:
//   clk, rst (async, active-low), rdy (global enable), clr_i (sync flush)
//   dispatch : en_i, opcode_i, pc_i, imm_i, r1/r2_data_i, r1/r2_id_i, id_i
//   status   : full_o, empty_o, count_o
//   ALU slot : alu_en_o + alu_* payload, alu_ready_i back-pressure
//   CDB      : cdb_en_i, cdb_id_i, cdb_data_i (NCDB packed ports)
module rs_age_ordered #(
    parameter int DEPTH  = 16,
    parameter int DATA_W = 32,
    parameter int ROB_W  = 4,
    parameter int OP_W   = 6,
    parameter int NCDB   = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rdy,
    input  logic                       clr_i,
    input  logic                       en_i,
    input  logic [OP_W-1:0]            opcode_i,
    input  logic [DATA_W-1:0]          pc_i,
    input  logic [DATA_W-1:0]          imm_i,
    input  logic [DATA_W-1:0]          r1_data_i,
    input  logic [DATA_W-1:0]          r2_data_i,
    input  logic [ROB_W-1:0]           r1_id_i,
    input  logic [ROB_W-1:0]           r2_id_i,
    input  logic [ROB_W-1:0]           id_i,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       alu_en_o,
    output logic [OP_W-1:0]            alu_opcode_o,
    output logic [DATA_W-1:0]          alu_pc_o,
    output logic [DATA_W-1:0]          alu_imm_o,
    output logic [DATA_W-1:0]          alu_r1_data_o,
    output logic [DATA_W-1:0]          alu_r2_data_o,
    output logic [ROB_W-1:0]           alu_id_o,
    input  logic                       alu_ready_i,
    input  logic [NCDB-1:0]            cdb_en_i,
    input  logic [NCDB*ROB_W-1:0]      cdb_id_i,
    input  logic [NCDB*DATA_W-1:0]     cdb_data_i
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = $clog2(DEPTH);

    // Entry state
    logic [DEPTH-1:0]  r_valid;
    logic [DEPTH-1:0]  r_rdy1;
    logic [DEPTH-1:0]  r_rdy2;
    logic [OP_W-1:0]   r_op  [DEPTH];
    logic [DATA_W-1:0] r_pc  [DEPTH];
    logic [DATA_W-1:0] r_imm [DEPTH];
    logic [DATA_W-1:0] r_v1  [DEPTH];
    logic [DATA_W-1:0] r_v2  [DEPTH];
    logic [ROB_W-1:0]  r_q1  [DEPTH];
    logic [ROB_W-1:0]  r_q2  [DEPTH];
    logic [ROB_W-1:0]  r_id  [DEPTH];
    // r_older[i][j] == 1 : entry i is older than entry j
    logic [DEPTH-1:0]  r_older [DEPTH];
    logic [CW-1:0]     r_count;

    logic [DEPTH-1:0]  w_elig;
    logic [DEPTH-1:0]  w_blk;
    logic [DEPTH-1:0]  w_iss_oh;
    logic [IW-1:0]     w_iss_idx;
    logic              w_any_elig;
    logic [DEPTH-1:0]  w_free_oh;
    logic [IW-1:0]     w_free_idx;
    logic [DATA_W:0]   w_s1;
    logic [DATA_W:0]   w_s2;
    logic              w_d_rdy1;
    logic              w_d_rdy2;
    logic [DATA_W-1:0] w_d_v1;
    logic [DATA_W-1:0] w_d_v2;
    logic [DATA_W:0]   w_wk1 [DEPTH];
    logic [DATA_W:0]   w_wk2 [DEPTH];
    logic              w_full;
    logic              w_slot_free;
    logic              w_acc;
    logic              w_fast;
    logic              w_store;
    logic              w_issue;

    // Returns {hit, data}; lowest matching port wins.
    function automatic logic [DATA_W:0] f_snoop(
        input logic [ROB_W-1:0]       tag,
        input logic [NCDB-1:0]        en,
        input logic [NCDB*ROB_W-1:0]  ids,
        input logic [NCDB*DATA_W-1:0] dat
    );
        logic [DATA_W:0] res;
        res = '0;
        for (int k = NCDB - 1; k >= 0; k--) begin
            if (en[k] && ids[k*ROB_W +: ROB_W] == tag) begin
                res = {1'b1, dat[k*DATA_W +: DATA_W]};
            end
        end
        return res;
    endfunction

    assign w_full  = (r_count == CW'(DEPTH));
    assign full_o  = w_full;
    assign empty_o = (r_count == '0);
    assign count_o = r_count;

    assign w_elig     = r_valid & r_rdy1 & r_rdy2;
    assign w_any_elig = |w_elig;

    // An eligible entry is blocked if any other eligible entry is older.
    always_comb begin
        w_blk     = '0;
        w_iss_oh  = '0;
        w_iss_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            for (int j = 0; j < DEPTH; j++) begin
                w_blk[i] = w_blk[i] | (w_elig[j] & r_older[j][i]);
            end
            if (w_elig[i] && !w_blk[i]) begin
                w_iss_oh[i] = 1'b1;
                w_iss_idx   = IW'(i);
            end
        end
    end

    // Lowest-index free entry (scan downward, last hit wins).
    always_comb begin
        w_free_oh  = '0;
        w_free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!r_valid[i]) begin
                w_free_oh    = '0;
                w_free_oh[i] = 1'b1;
                w_free_idx   = IW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            w_wk1[i] = f_snoop(r_q1[i], cdb_en_i, cdb_id_i, cdb_data_i);
            w_wk2[i] = f_snoop(r_q2[i], cdb_en_i, cdb_id_i, cdb_data_i);
        end
    end

    // Dispatch-time operand capture, including same-cycle CDB bypass.
    assign w_s1     = f_snoop(r1_id_i, cdb_en_i, cdb_id_i, cdb_data_i);
    assign w_s2     = f_snoop(r2_id_i, cdb_en_i, cdb_id_i, cdb_data_i);
    assign w_d_rdy1 = (r1_id_i == '0) | w_s1[DATA_W];
    assign w_d_rdy2 = (r2_id_i == '0) | w_s2[DATA_W];
    assign w_d_v1   = (r1_id_i == '0) ? r1_data_i : w_s1[DATA_W-1:0];
    assign w_d_v2   = (r2_id_i == '0) ? r2_data_i : w_s2[DATA_W-1:0];

    // Fast path only for register-ready ops (tag 0), never bypassed ones.
    assign w_slot_free = !alu_en_o || alu_ready_i;
    assign w_acc       = en_i && !w_full;
    assign w_fast      = w_acc && (r1_id_i == '0) && (r2_id_i == '0)
                         && w_slot_free && !w_any_elig;
    assign w_store     = w_acc && !w_fast;
    assign w_issue     = w_slot_free && w_any_elig;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid       <= '0;
            r_rdy1        <= '0;
            r_rdy2        <= '0;
            r_count       <= '0;
            alu_en_o      <= 1'b0;
            alu_opcode_o  <= '0;
            alu_pc_o      <= '0;
            alu_imm_o     <= '0;
            alu_r1_data_o <= '0;
            alu_r2_data_o <= '0;
            alu_id_o      <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_older[i] <= '0;
            end
        end else if (rdy) begin
            if (clr_i) begin
                r_valid       <= '0;
                r_rdy1        <= '0;
                r_rdy2        <= '0;
                r_count       <= '0;
                alu_en_o      <= 1'b0;
                alu_opcode_o  <= '0;
                alu_pc_o      <= '0;
                alu_imm_o     <= '0;
                alu_r1_data_o <= '0;
                alu_r2_data_o <= '0;
                alu_id_o      <= '0;
                for (int i = 0; i < DEPTH; i++) begin
                    r_older[i] <= '0;
                end
            end else begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (w_issue && w_iss_oh[i]) begin
                        r_valid[i] <= 1'b0;
                    end else if (r_valid[i]) begin
                        if (!r_rdy1[i] && w_wk1[i][DATA_W]) r_rdy1[i] <= 1'b1;
                        if (!r_rdy2[i] && w_wk2[i][DATA_W]) r_rdy2[i] <= 1'b1;
                    end
                end
                if (w_store) begin
                    r_valid[w_free_idx] <= 1'b1;
                    r_rdy1[w_free_idx]  <= w_d_rdy1;
                    r_rdy2[w_free_idx]  <= w_d_rdy2;
                    // Everyone becomes older than the newcomer; the
                    // row clear comes last so r_older[n][n] stays 0.
                    for (int i = 0; i < DEPTH; i++) begin
                        r_older[i][w_free_idx] <= 1'b1;
                    end
                    r_older[w_free_idx] <= '0;
                end
                r_count <= r_count + CW'(w_store) - CW'(w_issue);
                if (w_slot_free) begin
                    if (w_any_elig) begin
                        alu_en_o      <= 1'b1;
                        alu_opcode_o  <= r_op[w_iss_idx];
                        alu_pc_o      <= r_pc[w_iss_idx];
                        alu_imm_o     <= r_imm[w_iss_idx];
                        alu_r1_data_o <= r_v1[w_iss_idx];
                        alu_r2_data_o <= r_v2[w_iss_idx];
                        alu_id_o      <= r_id[w_iss_idx];
                    end else if (w_fast) begin
                        alu_en_o      <= 1'b1;
                        alu_opcode_o  <= opcode_i;
                        alu_pc_o      <= pc_i;
                        alu_imm_o     <= imm_i;
                        alu_r1_data_o <= r1_data_i;
                        alu_r2_data_o <= r2_data_i;
                        alu_id_o      <= id_i;
                    end else begin
                        alu_en_o <= 1'b0;
                    end
                end
            end
        end
    end

    // Entry payload needs no reset: it is only read while r_valid is set.
    always_ff @(posedge clk) begin
        if (rdy && !clr_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_valid[i] && !r_rdy1[i] && w_wk1[i][DATA_W]) begin
                    r_v1[i] <= w_wk1[i][DATA_W-1:0];
                end
                if (r_valid[i] && !r_rdy2[i] && w_wk2[i][DATA_W]) begin
                    r_v2[i] <= w_wk2[i][DATA_W-1:0];
                end
            end
            if (w_store) begin
                r_op[w_free_idx]  <= opcode_i;
                r_pc[w_free_idx]  <= pc_i;
                r_imm[w_free_idx] <= imm_i;
                r_v1[w_free_idx]  <= w_d_v1;
                r_v2[w_free_idx]  <= w_d_v2;
                r_q1[w_free_idx]  <= r1_id_i;
                r_q2[w_free_idx]  <= r2_id_i;
                r_id[w_free_idx]  <= id_i;
            end
        end
    end

    logic w_unused;
    assign w_unused = ^w_free_oh;

endmodule

// File: doc/rs_age_ordered.md
Name: rs_age_ordered

Overview:
- Parametrised reservation station for the Tomasulo core. Sits between the dispatcher and one ALU.
- Buffers instructions until both operands are available. Captures operands from NCDB broadcast buses.
- Issues the oldest ready entry into a registered ALU output slot. The slot has a valid/ready handshake, so the ALU can back-pressure it.
- Generalises the previous RS with configurable depth, data/ROB widths and CDB count, plus oldest-first selection, ALU back-pressure, CDB bypass at dispatch and an occupancy count.

Parameters:
DEPTH, 16, number of entries (power of two, >=2)
DATA_W, 32, operand/pc/imm width
ROB_W, 4, ROB tag width; tag 0 means "no dependency"
OP_W, 6, opcode width
NCDB, 2, number of CDB broadcast ports

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
rdy  in  1  global enable; when low, all state holds
clr_i  in  1  synchronous flush (mispredict)
en_i  in  1  dispatch valid
opcode_i  in  OP_W  opcode
pc_i  in  DATA_W  instruction pc
imm_i  in  DATA_W  immediate
r1_data_i  in  DATA_W  operand 1 value (valid when r1_id_i==0)
r2_data_i  in  DATA_W  operand 2 value (valid when r2_id_i==0)
r1_id_i  in  ROB_W  operand 1 producer tag
r2_id_i  in  ROB_W  operand 2 producer tag
id_i  in  ROB_W  destination ROB tag
full_o  out  1  count_o==DEPTH
empty_o  out  1  count_o==0
count_o  out  $clog2(DEPTH+1)  valid entries
alu_en_o  out  1  output slot valid
alu_opcode_o  out  OP_W  opcode
alu_pc_o  out  DATA_W  pc
alu_imm_o  out  DATA_W  immediate
alu_r1_data_o  out  DATA_W  operand 1
alu_r2_data_o  out  DATA_W  operand 2
alu_id_o  out  ROB_W  destination tag
alu_ready_i  in  1  ALU accepts the slot this cycle
cdb_en_i  in  NCDB  per-port broadcast valid
cdb_id_i  in  NCDB*ROB_W  per-port tag, port k at [k*ROB_W +: ROB_W]
cdb_data_i  in  NCDB*DATA_W  per-port data

Behaviour:
- Reset (rst==0, async): all entries invalid, count_o=0, empty_o=1, full_o=0, alu_en_o=0. The alu_* payload outputs reset to 0.
- rdy==0: no dispatch, wakeup, issue or flush. Every register holds. CDB traffic is ignored (upstream stalls too).
- clr_i==1 with rdy==1: same result as reset at the clock edge. Overrides any en_i, CDB or issue activity in the same cycle.
- full_o and empty_o derive combinationally from the count register.
- Dispatch:
  - Accepted only when en_i==1 and full_o==0.
  - en_i while full is dropped. The dispatcher must not do this.
  - An issue in the same cycle does not free a slot for that cycle's dispatch.
- Allocation: lowest-index free entry.
- Each entry carries an age rank. A new entry is younger than all resident entries (age matrix or equivalent).
- Operand capture at dispatch, per operand:
  - id==0 → ready, data from input.
  - Otherwise, if any cdb_en_i[k] has a tag equal to id in the same cycle → ready, data from the lowest such k (CDB bypass).
  - Otherwise not ready, tag stored.
- Wakeup: every cycle, each valid entry with an unready operand whose tag matches an active CDB port captures that data and sets ready. If several ports match, the lowest port wins.
- Eligibility: an entry is eligible when both ready bits are set in registered state. Wakeup at edge N makes the entry eligible after N; earliest alu_en_o is at edge N+1.
- Output slot may load at an edge when alu_en_o==0, or when alu_en_o==1 and alu_ready_i==1. Otherwise it holds, payload stable. Source priority:
  1. Oldest eligible stored entry: slot loads it, entry freed at the same edge.
  2. Fast path, only if no stored entry is eligible: a dispatch with r1_id_i==0 and r2_id_i==0 goes straight into the slot and takes no entry, even when full_o==1 is not asserted.
  3. Otherwise: alu_en_o goes to 0 if the slot was consumed.
- Fast path vs. free slot: a fully-ready dispatch arriving while the slot is unavailable, or while a stored entry is eligible, is stored normally.
- count_o update per edge: +1 for a stored dispatch, −1 for a stored-entry issue. Both can happen in one cycle (net 0).
- Tag 0 on the CDB is never broadcast. Behaviour for it is undefined.

Test Plan:
- Fast path: empty RS, alu_ready_i=1, dispatch op=3, r1_id=0, r2_id=0, r1=5, r2=7, id=2 → next edge alu_en_o=1, alu_r1=5, alu_r2=7, alu_id=2; count_o stays 0.
- Wakeup: dispatch r1_id=4 (r2 ready=9). Next cycle CDB0 tag 4 data 0x11 → alu_en_o at the following edge with alu_r1=0x11, alu_r2=9, count_o 1→0.
- Oldest-first: dispatch A (tag 5 pending), then B (tag 6 pending). Broadcast tags 6 and 5 on CDB0/CDB1 in the same cycle → A issues first, B one cycle later.
- Back-pressure: alu_ready_i=0 with slot valid for 3 cycles while 2 more entries become eligible → payload unchanged. Release alu_ready_i → entries drain one per cycle in age order.
- Full: fill DEPTH=16 pending entries → full_o=1, count_o=16. A 17th en_i is dropped. One issue → full_o=0 next cycle.
- Flush/reset: clr_i mid-fill (count_o=7) with a concurrent CDB hit and en_i → count_o=0, empty_o=1, alu_en_o=0. Async rst low mid-cycle clears immediately, without waiting for a clock edge.
